// File: rtl/video_gen_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : video_gen_frame_sequencer                                    |
// | Description : Frame-accurate run controller for the test-video generator. |
// |               Enables the sync generator, starts and stops runs on frame   |
// |               boundaries, counts frames, rotates the test pattern every    |
// |               PAT_FRAMES frames and reports done/timeout status.           |
// |               Optional macro VIDEO_SEQ_SIZE_CHECK_EN adds a frame-geometry |
// |               checker (hactive/vactive inputs, sticky size_err output).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module video_gen_frame_sequencer #(
    parameter int PAT_NUM    = 8,
    parameter int PSEL_W     = 3,
    parameter int PAT_FRAMES = 4,
    parameter int TO_W       = 24,
    parameter int TO_CYCLES  = 4000000
) (
    input  logic              pclk,
    input  logic              prst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              abort,
    input  logic [15:0]       frame_num,
    input  logic              vsync,
    input  logic              de,
`ifdef VIDEO_SEQ_SIZE_CHECK_EN
    input  logic [15:0]       hactive,
    input  logic [15:0]       vactive,
    output logic              size_err,
`endif
    output logic              gen_enable,
    output logic [PSEL_W-1:0] pattern_sel,
    output logic [15:0]       frame_cnt,
    output logic              sof,
    output logic              done,
    output logic              busy,
    output logic              timeout_err
);

    // State encoding
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_WAIT_SOF = 2'd1;
    localparam logic [1:0] c_ST_RUN      = 2'd2;
    localparam logic [1:0] c_ST_DONE     = 2'd3;

    // Per-pattern frame counter only needs to hold 0..PAT_FRAMES-1
    localparam int                c_PF_W      = (PAT_FRAMES > 1) ? $clog2(PAT_FRAMES) : 1;
    localparam logic [c_PF_W-1:0] c_PF_LAST   = c_PF_W'(PAT_FRAMES - 1);
    localparam logic [PSEL_W-1:0] c_PSEL_LAST = PSEL_W'(PAT_NUM - 1);
    localparam logic [TO_W-1:0]   c_TO_LAST   = TO_W'(TO_CYCLES - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_vsync_d;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_stop_req;
    logic [c_PF_W-1:0] r_pat_frm;
    logic              r_gen_enable;
    logic [PSEL_W-1:0] r_pattern_sel;
    logic [15:0]       r_frame_cnt;
    logic              r_sof;
    logic              r_timeout_err;

    logic              w_vs_rise;
    logic              w_limit;
    logic              w_accept;
    logic              w_first_sof;
    logic              w_count_frame;
    logic              w_end_run;
    logic              w_timeout;
    logic              w_abort;

    assign w_vs_rise = vsync & ~r_vsync_d;

    // A run ends at the boundary if a stop is pending (or arriving right now)
    // or the requested frame count has been started; equality only, so
    // lowering frame_num below frame_cnt mid-run leaves the run open-ended.
    assign w_limit = r_stop_req | stop |
                     ((frame_num != 16'd0) && (r_frame_cnt == frame_num));

    // State register
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle action strobes; abort has top priority
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_first_sof   = 1'b0;
        w_count_frame = 1'b0;
        w_end_run     = 1'b0;
        w_timeout     = 1'b0;
        w_abort       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_ST_WAIT_SOF;
                end
            end
            c_ST_WAIT_SOF: begin
                if (abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else if (w_vs_rise) begin
                    w_first_sof = 1'b1;
                    w_state_nxt = c_ST_RUN;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_RUN: begin
                if (abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else if (w_vs_rise) begin
                    if (w_limit) begin
                        w_end_run   = 1'b1;
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_count_frame = 1'b1;
                    end
                end
            end
            c_ST_DONE: begin
                w_abort     = abort;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Run datapath: enable, frame/pattern counters, timeout and status flags
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_vsync_d     <= 1'b0;
            r_to_cnt      <= '0;
            r_stop_req    <= 1'b0;
            r_pat_frm     <= '0;
            r_gen_enable  <= 1'b0;
            r_pattern_sel <= '0;
            r_frame_cnt   <= 16'd0;
            r_sof         <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            r_sof     <= w_first_sof | w_count_frame;

            if (w_accept) begin
                r_gen_enable  <= 1'b1;
                r_frame_cnt   <= 16'd0;
                r_pattern_sel <= '0;
                r_pat_frm     <= '0;
                r_to_cnt      <= '0;
                r_stop_req    <= 1'b0;
                r_timeout_err <= 1'b0;
            end else begin
                if (w_abort || w_timeout || w_end_run) begin
                    r_gen_enable <= 1'b0;
                end
                if (w_timeout) begin
                    r_timeout_err <= 1'b1;
                end
                if (r_state == c_ST_WAIT_SOF) begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
                if ((r_state == c_ST_RUN) && stop) begin
                    r_stop_req <= 1'b1;
                end
                if (w_first_sof) begin
                    r_frame_cnt <= 16'd1;
                end
                if (w_count_frame) begin
                    if (r_frame_cnt != 16'hFFFF) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                    if (r_pat_frm == c_PF_LAST) begin
                        r_pat_frm <= '0;
                        if (r_pattern_sel == c_PSEL_LAST) begin
                            r_pattern_sel <= '0;
                        end else begin
                            r_pattern_sel <= r_pattern_sel + PSEL_W'(1);
                        end
                    end else begin
                        r_pat_frm <= r_pat_frm + c_PF_W'(1);
                    end
                end
            end
        end
    end

    assign gen_enable  = r_gen_enable;
    assign pattern_sel = r_pattern_sel;
    assign frame_cnt   = r_frame_cnt;
    assign sof         = r_sof;
    assign done        = (r_state == c_ST_DONE);
    assign busy        = (r_state != c_ST_IDLE);
    assign timeout_err = r_timeout_err;

`ifdef VIDEO_SEQ_SIZE_CHECK_EN
    logic        r_de_d;
    logic [15:0] r_line_len;
    logic [15:0] r_line_cnt;
    logic        r_sz_armed;
    logic        r_size_err;
    logic        w_de_fall;
    logic [15:0] w_lines;

    assign w_de_fall = r_de_d & ~de;
    // A line ending on the same cycle as vsync still belongs to the old frame
    assign w_lines   = r_line_cnt + 16'(w_de_fall);

    // Geometry checker; the first frame of a run is only observed, never judged
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_de_d     <= 1'b0;
            r_line_len <= 16'd0;
            r_line_cnt <= 16'd0;
            r_sz_armed <= 1'b0;
            r_size_err <= 1'b0;
        end else begin
            r_de_d <= de;
            if (w_accept) begin
                r_line_len <= 16'd0;
                r_line_cnt <= 16'd0;
                r_sz_armed <= 1'b0;
                r_size_err <= 1'b0;
            end else if (r_state == c_ST_RUN) begin
                if (de) begin
                    r_line_len <= r_line_len + 16'd1;
                end else if (w_de_fall) begin
                    if (r_sz_armed && (r_line_len != hactive)) begin
                        r_size_err <= 1'b1;
                    end
                    r_line_len <= 16'd0;
                end
                if (w_vs_rise) begin
                    if (r_sz_armed && (w_lines != vactive)) begin
                        r_size_err <= 1'b1;
                    end
                    r_line_cnt <= 16'd0;
                    r_sz_armed <= 1'b1;
                end else if (w_de_fall) begin
                    r_line_cnt <= r_line_cnt + 16'd1;
                end
            end
        end
    end

    assign size_err = r_size_err;
`else
    // de only feeds the optional geometry checker
    logic w_de_unused;
    assign w_de_unused = de;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_gen_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_video_gen_frame_sequencer                                 |
// | Description : Directed self-checking bench for video_gen_frame_sequencer.  |
// |               sof and done events are matched against scoreboard queues.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_video_gen_frame_sequencer;

    localparam int PAT_NUM    = 8;
    localparam int PSEL_W     = 3;
    localparam int PAT_FRAMES = 4;
    localparam int TO_W       = 24;
    localparam int TO_CYCLES  = 100;
    localparam int LINES      = 3;
    localparam int HACT       = 4;

    logic              pclk;
    logic              prst_n;
    logic              start;
    logic              stop;
    logic              abort;
    logic [15:0]       frame_num;
    logic              vsync;
    logic              de;
    logic              gen_enable;
    logic [PSEL_W-1:0] pattern_sel;
    logic [15:0]       frame_cnt;
    logic              sof;
    logic              done;
    logic              busy;
    logic              timeout_err;
`ifdef VIDEO_SEQ_SIZE_CHECK_EN
    logic [15:0]       hactive;
    logic [15:0]       vactive;
    logic              size_err;
`endif

    int checks = 0;
    int errors = 0;

    int sof_fc_q[$];
    int sof_ps_q[$];
    int done_q[$];

    video_gen_frame_sequencer #(
        .PAT_NUM    (PAT_NUM),
        .PSEL_W     (PSEL_W),
        .PAT_FRAMES (PAT_FRAMES),
        .TO_W       (TO_W),
        .TO_CYCLES  (TO_CYCLES)
    ) dut (
        .pclk        (pclk),
        .prst_n      (prst_n),
        .start       (start),
        .stop        (stop),
        .abort       (abort),
        .frame_num   (frame_num),
        .vsync       (vsync),
        .de          (de),
`ifdef VIDEO_SEQ_SIZE_CHECK_EN
        .hactive     (hactive),
        .vactive     (vactive),
        .size_err    (size_err),
`endif
        .gen_enable  (gen_enable),
        .pattern_sel (pattern_sel),
        .frame_cnt   (frame_cnt),
        .sof         (sof),
        .done        (done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge pclk);
    endtask

    // One frame: 2-cycle vsync pulse, then LINES lines of hact de-high cycles
    task automatic drive_frame(input int short_line);
        step(); vsync = 1'b1;
        step();
        step(); vsync = 1'b0;
        for (int l = 0; l < LINES; l++) begin
            step();
            step(); de = 1'b1;
            repeat ((l == short_line) ? HACT - 1 : HACT) step();
            de = 1'b0;
        end
        step();
    endtask

    task automatic pulse_start();
        step(); start = 1'b1;
        step(); start = 1'b0;
    endtask

    task automatic expect_sof(input int fc);
        sof_fc_q.push_back(fc);
        sof_ps_q.push_back(((fc - 1) / PAT_FRAMES) % PAT_NUM);
    endtask

    // Scoreboard: every sof/done the DUT produces must match a queued entry
    always @(negedge pclk) begin
        if (sof === 1'b1) begin
            chk("sof_expected", 32'(sof_fc_q.size() > 0), 32'd1);
            if (sof_fc_q.size() > 0) begin
                chk("sof_frame_cnt", 32'(frame_cnt), 32'(sof_fc_q.pop_front()));
                chk("sof_pattern_sel", 32'(pattern_sel), 32'(sof_ps_q.pop_front()));
            end
        end
        if (done === 1'b1) begin
            chk("done_expected", 32'(done_q.size() > 0), 32'd1);
            if (done_q.size() > 0) begin
                chk("done_frame_cnt", 32'(frame_cnt), 32'(done_q.pop_front()));
            end
        end
    end

    initial begin
        prst_n    = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        abort     = 1'b0;
        frame_num = 16'd0;
        vsync     = 1'b0;
        de        = 1'b0;
`ifdef VIDEO_SEQ_SIZE_CHECK_EN
        hactive   = 16'(HACT);
        vactive   = 16'(LINES);
`endif
        repeat (3) step();
        chk("rst_gen_enable", 32'(gen_enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        prst_n = 1'b1;
        repeat (2) step();

        // Run of 3 frames ending on the 4th vsync
        frame_num = 16'd3;
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_gen_enable", 32'(gen_enable), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            expect_sof(k);
            drive_frame(-1);
        end
        done_q.push_back(3);
        step(); vsync = 1'b1;
        step();
        chk("t1_gen_enable_off", 32'(gen_enable), 32'd0);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd3);
        step();
        chk("t1_done_once", 32'(done), 32'd0);
        chk("t1_busy_off", 32'(busy), 32'd0);
        vsync = 1'b0;

        // Free run of 33 frames with pattern rotation, then graceful stop
        frame_num = 16'd0;
        pulse_start();
        for (int k = 1; k <= 33; k++) begin
            expect_sof(k);
            drive_frame(-1);
            if (k == 32) chk("t2_psel_32", 32'(pattern_sel), 32'd7);
        end
        chk("t2_psel_wrap", 32'(pattern_sel), 32'd0);
        step(); stop = 1'b1;
        step(); stop = 1'b0;
        repeat (3) step();
        chk("t2_busy_after_stop", 32'(busy), 32'd1);
        chk("t2_no_early_done", 32'(gen_enable), 32'd1);
        done_q.push_back(33);
        step(); vsync = 1'b1;
        step();
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd33);
        step(); vsync = 1'b0;
        chk("t2_idle", 32'(busy), 32'd0);
        drive_frame(-1);
        chk("t2_stays_idle", 32'(gen_enable), 32'd0);

        // Stop coinciding with the frame limit gives a single done
        frame_num = 16'd2;
        pulse_start();
        expect_sof(1); drive_frame(-1);
        expect_sof(2); drive_frame(-1);
        done_q.push_back(2);
        step(); vsync = 1'b1; stop = 1'b1;
        step(); stop = 1'b0;
        chk("t3_done", 32'(done), 32'd1);
        step(); vsync = 1'b0;
        chk("t3_done_once", 32'(done), 32'd0);
        chk("t3_idle", 32'(busy), 32'd0);

        // Start-of-frame timeout with vsync held low
        frame_num = 16'd0;
        pulse_start();
        repeat (TO_CYCLES - 1) step();
        chk("t4_still_waiting", 32'(busy), 32'd1);
        chk("t4_no_err_yet", 32'(timeout_err), 32'd0);
        step();
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_timeout_err", 32'(timeout_err), 32'd1);
        chk("t4_gen_enable", 32'(gen_enable), 32'd0);
        repeat (3) step();
        chk("t4_sticky", 32'(timeout_err), 32'd1);
        pulse_start();
        chk("t4_err_cleared", 32'(timeout_err), 32'd0);
        step(); abort = 1'b1;
        step(); abort = 1'b0;
        chk("t4_abort_wait", 32'(busy), 32'd0);

        // Abort mid-line in frame 2; start while busy is ignored
        pulse_start();
        expect_sof(1); drive_frame(-1);
        expect_sof(2);
        step(); vsync = 1'b1;
        step();
        step(); vsync = 1'b0;
        step(); de = 1'b1;
        step();
        pulse_start();
        chk("t5_start_ignored", 32'(frame_cnt), 32'd2);
        chk("t5_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        step(); abort = 1'b0;
        chk("t5_gen_enable", 32'(gen_enable), 32'd0);
        chk("t5_busy_off", 32'(busy), 32'd0);
        chk("t5_frame_cnt_hold", 32'(frame_cnt), 32'd2);
        de = 1'b0;
        repeat (3) step();

        // Asynchronous reset during RUN
        pulse_start();
        expect_sof(1); drive_frame(-1);
        expect_sof(2); drive_frame(-1);
        chk("t6_pre_rst_cnt", 32'(frame_cnt), 32'd2);
        #2 prst_n = 1'b0;
        #1;
        chk("t6_rst_gen_enable", 32'(gen_enable), 32'd0);
        chk("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_psel", 32'(pattern_sel), 32'd0);
        step(); prst_n = 1'b1;
        drive_frame(-1);
        chk("t6_idle_after_rst", 32'(busy), 32'd0);

`ifdef VIDEO_SEQ_SIZE_CHECK_EN
        // Geometry checker: good frames clean, one short line sticks the flag
        pulse_start();
        for (int k = 1; k <= 3; k++) begin
            expect_sof(k);
            drive_frame(-1);
        end
        chk("sz_clean", 32'(size_err), 32'd0);
        expect_sof(4); drive_frame(1);
        chk("sz_err_set", 32'(size_err), 32'd1);
        expect_sof(5); drive_frame(-1);
        chk("sz_err_sticky", 32'(size_err), 32'd1);
        step(); abort = 1'b1;
        step(); abort = 1'b0;
        pulse_start();
        chk("sz_err_cleared", 32'(size_err), 32'd0);
        step(); abort = 1'b1;
        step(); abort = 1'b0;
`endif

        repeat (2) step();
        chk("sof_queue_drained", 32'(sof_fc_q.size()), 32'd0);
        chk("done_queue_drained", 32'(done_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
